// File: rtl/tboom_rmt_pkg.sv
// Shared types and widths for the freelist controller slice.
package tboom_rmt_pkg;

  localparam int DATA_WIDTH_D       = 6;
  localparam int MEMORY_WIDTH_D     = 64;
  localparam int CHECKPOINT_DEPTH_D = 8;
  localparam int TAGW               = $clog2(CHECKPOINT_DEPTH_D);
  localparam int CNTW               = $clog2(MEMORY_WIDTH_D) + 1;

  typedef logic [TAGW-1:0]         tag_t;
  typedef logic [DATA_WIDTH_D-1:0] pdst_t;

  typedef enum logic {
    RUN     = 1'b0,
    RESTORE = 1'b1
  } ctrl_state_e;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/tboom_ckpt_tag_ring.sv
// Age-ordered branch tag ring: allocation at tail, in-order retirement at head,
// and squash of everything younger than a mispredicted tag.
module tboom_ckpt_tag_ring #(
  parameter  int DEPTH = 8,
  localparam int TW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_alloc,
  input  logic          i_resolve_valid,
  input  logic [TW-1:0] i_resolve_tag,
  input  logic          i_squash,
  input  logic [TW-1:0] i_squash_tag,
  output logic [TW-1:0] o_tail_tag,
  output logic          o_full,
  output logic          o_resolve_err
);

  logic [TW:0]      r_head;
  logic [TW:0]      r_tail;
  logic [DEPTH-1:0] r_done;

  logic [TW:0]      w_occ;
  logic [TW-1:0]    w_head_idx;
  logic [TW-1:0]    w_res_off;
  logic [TW-1:0]    w_sq_off;
  logic             w_res_live;
  logic             w_head_done;
  logic [DEPTH-1:0] w_done_next;

  assign w_head_idx    = r_head[TW-1:0];
  assign w_occ         = r_tail - r_head;
  assign w_res_off     = i_resolve_tag - w_head_idx;
  assign w_sq_off      = i_squash_tag - w_head_idx;
  assign w_res_live    = ({1'b0, w_res_off} < w_occ);
  assign o_resolve_err = i_resolve_valid & ~w_res_live;
  assign o_tail_tag    = r_tail[TW-1:0];
  // Occupancy never exceeds DEPTH, so its MSB alone marks a full ring.
  assign o_full        = w_occ[TW];

  // A resolve of the head tag retires it in the same cycle it arrives.
  assign w_head_done = (w_occ != '0) &
                       (r_done[w_head_idx] |
                        (i_resolve_valid & w_res_live & (i_resolve_tag == w_head_idx)));

  always_comb begin
    w_done_next = r_done;
    if (i_resolve_valid && w_res_live)
      w_done_next[i_resolve_tag] = 1'b1;
    if (w_head_done)
      w_done_next[w_head_idx] = 1'b0;
    if (i_squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((TW'(i) - w_head_idx) > w_sq_off)
          w_done_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_done <= '0;
    end else begin
      r_done <= w_done_next;
      if (w_head_done)
        r_head <= r_head + (TW+1)'(1);
      // The mispredicted tag itself stays live; only younger tags are dropped.
      if (i_squash)
        r_tail <= r_head + {1'b0, w_sq_off} + (TW+1)'(1);
      else if (i_alloc)
        r_tail <= r_tail + (TW+1)'(1);
    end
  end

endmodule

// File: rtl/tboom_freelist_ctrl.sv
// Freelist controller: grants 2-wide pdst allocation and frees, manages branch
// checkpoints, and tracks a shadow free count that survives restores.
module tboom_freelist_ctrl
  import tboom_rmt_pkg::*;
#(
  parameter  int DATA_WIDTH       = 6,
  parameter  int MEMORY_WIDTH     = 64,
  parameter  int CHECKPOINT_DEPTH = 8,
  parameter  int INIT_FREE        = 32,
  localparam int TW               = $clog2(CHECKPOINT_DEPTH),
  localparam int CW               = $clog2(MEMORY_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ren_req,
  output logic                  ren_ready,
  output logic [DATA_WIDTH-1:0] ren_pdst0,
  output logic [DATA_WIDTH-1:0] ren_pdst1,
  input  logic                  br_valid,
  output logic                  br_ready,
  output logic [TW-1:0]         br_tag,
  input  logic                  resolve_valid,
  input  logic [TW-1:0]         resolve_tag,
  input  logic                  mispred_valid,
  input  logic [TW-1:0]         mispred_tag,
  input  logic [1:0]            free_valid,
  input  logic [DATA_WIDTH-1:0] free_pdst0,
  input  logic [DATA_WIDTH-1:0] free_pdst1,
  output logic                  free_ready,
  output logic                  fl_i0_read_enable,
  output logic                  fl_i1_read_enable,
  output logic                  fl_i0_write_enable,
  output logic                  fl_i1_write_enable,
  output logic [DATA_WIDTH-1:0] fl_i0_data_in,
  output logic [DATA_WIDTH-1:0] fl_i1_data_in,
  output logic                  fl_checkpoint,
  output logic                  fl_restore,
  output logic [TW-1:0]         fl_checkpoint_restore_pos,
  input  logic [DATA_WIDTH-1:0] fl_i0_data_out,
  input  logic [DATA_WIDTH-1:0] fl_i1_data_out,
  input  logic                  fl_invalid_read,
  input  logic                  fl_invalid_write,
  output logic [CW-1:0]         free_count,
  output logic                  err
);

  ctrl_state_e   r_state;
  logic [TW-1:0] r_mis_tag;
  logic [CW-1:0] r_free_count;
  logic [CW-1:0] r_ckpt_count [CHECKPOINT_DEPTH];
  logic          r_err;

  logic          w_run;
  logic          w_restoring;
  logic          w_alloc_ok;
  logic          w_full;
  logic          w_ckpt;
  logic          w_res_valid;
  logic          w_res_err;
  logic [TW-1:0] w_tail_tag;
  logic [CW-1:0] w_req_n;
  logic [CW-1:0] w_alloc_n;
  logic [CW-1:0] w_free_n;

  // A mispredict in flight or about to be taken freezes all handshakes.
  assign w_restoring = rst_n & (r_state == RESTORE);
  assign w_run       = rst_n & (r_state == RUN) & ~mispred_valid;

  assign w_req_n    = CW'(popcount2(ren_req));
  assign w_alloc_ok = (w_req_n <= r_free_count);

  assign ren_ready  = w_run & w_alloc_ok & (~br_valid | ~w_full);
  assign br_ready   = w_run & ~w_full & (~br_valid | w_alloc_ok);
  assign free_ready = w_run;

  assign fl_i0_read_enable  = ren_req[0] & ren_ready;
  assign fl_i1_read_enable  = ren_req[1] & ren_ready;
  assign fl_i0_write_enable = free_valid[0] & free_ready;
  assign fl_i1_write_enable = free_valid[1] & free_ready;
  assign fl_i0_data_in      = free_pdst0;
  assign fl_i1_data_in      = free_pdst1;

  // A lone lane-1 request still takes the head entry.
  assign ren_pdst0 = fl_i0_data_out;
  assign ren_pdst1 = (ren_req == 2'b10) ? fl_i0_data_out : fl_i1_data_out;

  assign w_ckpt                    = br_valid & br_ready;
  assign fl_checkpoint             = w_ckpt;
  assign fl_restore                = w_restoring;
  assign fl_checkpoint_restore_pos = w_restoring ? r_mis_tag : w_tail_tag;
  assign br_tag                    = w_tail_tag;

  assign w_alloc_n = CW'(popcount2({fl_i1_read_enable, fl_i0_read_enable}));
  assign w_free_n  = CW'(popcount2({fl_i1_write_enable, fl_i0_write_enable}));

  assign w_res_valid = rst_n & resolve_valid &
                       ~((r_state == RUN) & mispred_valid & (resolve_tag == mispred_tag));

  assign free_count = r_free_count;
  assign err        = r_err;

  tboom_ckpt_tag_ring #(
    .DEPTH (CHECKPOINT_DEPTH)
  ) u_tag_ring (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_alloc         (w_ckpt),
    .i_resolve_valid (w_res_valid),
    .i_resolve_tag   (resolve_tag),
    .i_squash        (w_restoring),
    .i_squash_tag    (r_mis_tag),
    .o_tail_tag      (w_tail_tag),
    .o_full          (w_full),
    .o_resolve_err   (w_res_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_mis_tag    <= '0;
      r_free_count <= CW'(INIT_FREE);
      r_err        <= 1'b0;
      for (int i = 0; i < CHECKPOINT_DEPTH; i++)
        r_ckpt_count[i] <= '0;
    end else begin
      if (fl_invalid_read || fl_invalid_write || w_res_err)
        r_err <= 1'b1;
      case (r_state)
        RUN: begin
          r_free_count <= r_free_count - w_alloc_n + w_free_n;
          // Snapshot excludes this cycle's own allocations and frees.
          if (w_ckpt)
            r_ckpt_count[w_tail_tag] <= r_free_count;
          if (mispred_valid) begin
            r_mis_tag <= mispred_tag;
            r_state   <= RESTORE;
          end
        end
        RESTORE: begin
          r_free_count <= r_ckpt_count[r_mis_tag];
          r_state      <= RUN;
          if (mispred_valid)
            r_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tboom_freelist_ctrl.sv
// Scoreboard bench for tboom_freelist_ctrl with a behavioural freelist model
// standing in for the datapath.
module tb_tboom_freelist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ren_req = '0;
  logic       br_valid = 1'b0;
  logic       resolve_valid = 1'b0;
  logic [2:0] resolve_tag = '0;
  logic       mispred_valid = 1'b0;
  logic [2:0] mispred_tag = '0;
  logic [1:0] free_valid = '0;
  logic [5:0] free_pdst0 = '0;
  logic [5:0] free_pdst1 = '0;
  logic       fl_invalid_read = 1'b0;
  logic       fl_invalid_write = 1'b0;

  logic       ren_ready, br_ready, free_ready, err;
  logic [5:0] ren_pdst0, ren_pdst1, fl_i0_data_in, fl_i1_data_in;
  logic [5:0] fl_i0_data_out, fl_i1_data_out;
  logic [2:0] br_tag, fl_checkpoint_restore_pos;
  logic       fl_i0_read_enable, fl_i1_read_enable, fl_i0_write_enable, fl_i1_write_enable;
  logic       fl_checkpoint, fl_restore;
  logic [6:0] free_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  tboom_freelist_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ren_req(ren_req), .ren_ready(ren_ready), .ren_pdst0(ren_pdst0), .ren_pdst1(ren_pdst1),
    .br_valid(br_valid), .br_ready(br_ready), .br_tag(br_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .mispred_valid(mispred_valid), .mispred_tag(mispred_tag),
    .free_valid(free_valid), .free_pdst0(free_pdst0), .free_pdst1(free_pdst1),
    .free_ready(free_ready),
    .fl_i0_read_enable(fl_i0_read_enable), .fl_i1_read_enable(fl_i1_read_enable),
    .fl_i0_write_enable(fl_i0_write_enable), .fl_i1_write_enable(fl_i1_write_enable),
    .fl_i0_data_in(fl_i0_data_in), .fl_i1_data_in(fl_i1_data_in),
    .fl_checkpoint(fl_checkpoint), .fl_restore(fl_restore),
    .fl_checkpoint_restore_pos(fl_checkpoint_restore_pos),
    .fl_i0_data_out(fl_i0_data_out), .fl_i1_data_out(fl_i1_data_out),
    .fl_invalid_read(fl_invalid_read), .fl_invalid_write(fl_invalid_write),
    .free_count(free_count), .err(err)
  );

  // Freelist datapath model: head/count ring with per-tag snapshots.
  logic [5:0] m_mem [64];
  logic [5:0] m_head;
  logic [6:0] m_cnt;
  logic [5:0] s_head [8];
  logic [6:0] s_cnt [8];

  assign fl_i0_data_out = m_mem[m_head];
  assign fl_i1_data_out = m_mem[m_head + 6'd1];

  always @(posedge clk) begin : fl_model
    logic [6:0] pops;
    logic [6:0] pushes;
    logic [5:0] wr;
    pops   = 7'(fl_i0_read_enable) + 7'(fl_i1_read_enable);
    pushes = 7'(fl_i0_write_enable) + 7'(fl_i1_write_enable);
    wr     = m_head + m_cnt[5:0];
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_mem[i] <= 6'(i + 32);
      m_head <= '0;
      m_cnt  <= 7'd32;
    end else if (fl_restore) begin
      m_head <= s_head[fl_checkpoint_restore_pos];
      m_cnt  <= s_cnt[fl_checkpoint_restore_pos];
    end else begin
      if (fl_checkpoint) begin
        s_head[fl_checkpoint_restore_pos] <= m_head;
        s_cnt[fl_checkpoint_restore_pos]  <= m_cnt;
      end
      if (fl_i0_write_enable) m_mem[wr] <= fl_i0_data_in;
      if (fl_i1_write_enable) m_mem[wr + 6'(fl_i0_write_enable)] <= fl_i1_data_in;
      m_head <= m_head + pops[5:0];
      m_cnt  <= m_cnt - pops + pushes;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ren_req = '0; br_valid = 1'b0; resolve_valid = 1'b0; resolve_tag = '0;
    mispred_valid = 1'b0; mispred_tag = '0; free_valid = '0;
    free_pdst0 = '0; free_pdst1 = '0; fl_invalid_read = 1'b0; fl_invalid_write = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    rst_n = 1'b0; ren_req = 2'b11; br_valid = 1'b1; free_valid = 2'b11;
    exp_q.push_back(32'd0);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({ren_ready, br_ready, free_ready, fl_i0_read_enable, fl_i1_read_enable,
             fl_i0_write_enable, fl_i1_write_enable, fl_checkpoint, fl_restore}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_gating: got %h expected %h", {ren_ready, br_ready, free_ready,
               fl_i0_read_enable, fl_i1_read_enable, fl_i0_write_enable, fl_i1_write_enable,
               fl_checkpoint, fl_restore}, e);
    end
    tick(); tick();
    rst_n = 1'b1; idle();
    exp_q.push_back(32'({7'd32, 1'b0, 3'd0}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({free_count, err, br_tag}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h expected %h", {free_count, err, br_tag}, e);
    end
  endtask

  task automatic test_alloc;
    logic [31:0] e;
    tick();
    ren_req = 2'b11;
    exp_q.push_back(32'({1'b1, 6'd32, 6'd33, 2'b11}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({ren_ready, ren_pdst0, ren_pdst1, fl_i1_read_enable, fl_i0_read_enable}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL alloc_pair: got %h expected %h",
               {ren_ready, ren_pdst0, ren_pdst1, fl_i1_read_enable, fl_i0_read_enable}, e);
    end
    tick();
    ren_req = 2'b00;
    exp_q.push_back(32'd30);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(free_count) !== e) begin
      tests_failed++;
      $display("[TB] FAIL alloc_count: got %0d expected %0d", free_count, e);
    end
  endtask

  task automatic test_drain;
    logic [31:0] e;
    tick();
    for (int i = 0; i < 14; i++) begin ren_req = 2'b11; tick(); end
    ren_req = 2'b01; tick();
    ren_req = 2'b11;
    exp_q.push_back(32'({7'd1, 3'b000}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({free_count, ren_ready, fl_i0_read_enable, fl_i1_read_enable}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL drain_block: got %h expected %h",
               {free_count, ren_ready, fl_i0_read_enable, fl_i1_read_enable}, e);
    end
    tick();
    ren_req = 2'b10;
    exp_q.push_back(32'({1'b1, 1'b0, 1'b1, 6'd63}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({ren_ready, fl_i0_read_enable, fl_i1_read_enable, ren_pdst1}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL lane1_only: got %h expected %h",
               {ren_ready, fl_i0_read_enable, fl_i1_read_enable, ren_pdst1}, e);
    end
    tick();
    ren_req = 2'b00;
    exp_q.push_back(32'({7'd0, 1'b1}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({free_count, ren_ready}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL empty_noreq: got %h expected %h", {free_count, ren_ready}, e);
    end
    tick();
    ren_req = 2'b01;
    exp_q.push_back(32'd0);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({ren_ready, fl_i0_read_enable}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL empty_block: got %h expected %h", {ren_ready, fl_i0_read_enable}, e);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      ren_req = 2'b00; free_valid = 2'b11;
      free_pdst0 = 6'(2 * i); free_pdst1 = 6'(2 * i + 1);
      tick();
    end
    idle();
    exp_q.push_back(32'd20);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(free_count) !== e) begin
      tests_failed++;
      $display("[TB] FAIL free_count: got %0d expected %0d", free_count, e);
    end
  endtask

  task automatic test_checkpoint_restore;
    logic [31:0] e;
    tick();
    ren_req = 2'b11; br_valid = 1'b1;
    exp_q.push_back(32'({1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 6'd0, 6'd1}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({ren_ready, br_ready, fl_checkpoint, br_tag, fl_checkpoint_restore_pos,
             ren_pdst0, ren_pdst1}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL ckpt_grant: got %h expected %h", {ren_ready, br_ready, fl_checkpoint,
               br_tag, fl_checkpoint_restore_pos, ren_pdst0, ren_pdst1}, e);
    end
    tick();
    br_valid = 1'b0; ren_req = 2'b11; tick();
    ren_req = 2'b01; free_valid = 2'b01; free_pdst0 = 6'd40; tick();
    idle();
    mispred_valid = 1'b1; mispred_tag = 3'd0; ren_req = 2'b11; free_valid = 2'b11; br_valid = 1'b1;
    exp_q.push_back(32'({7'd16, 9'd0}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({free_count, ren_ready, br_ready, free_ready, fl_i0_read_enable, fl_i1_read_enable,
             fl_i0_write_enable, fl_i1_write_enable, fl_checkpoint, fl_restore}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL mispred_freeze: got %h expected %h", {free_count, ren_ready, br_ready,
               free_ready, fl_i0_read_enable, fl_i1_read_enable, fl_i0_write_enable,
               fl_i1_write_enable, fl_checkpoint, fl_restore}, e);
    end
    tick();
    mispred_valid = 1'b0; br_valid = 1'b0;
    exp_q.push_back(32'({1'b1, 3'd0, 1'b0, 1'b0, 7'd16}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({fl_restore, fl_checkpoint_restore_pos, ren_ready, free_ready, free_count}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL restore_cycle: got %h expected %h",
               {fl_restore, fl_checkpoint_restore_pos, ren_ready, free_ready, free_count}, e);
    end
    tick();
    idle();
    exp_q.push_back(32'({7'd20, 3'd1, 1'b0, 6'd0, 6'd1}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({free_count, br_tag, fl_restore, ren_pdst0, ren_pdst1}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL after_restore: got %h expected %h",
               {free_count, br_tag, fl_restore, ren_pdst0, ren_pdst1}, e);
    end
    tick();
    resolve_valid = 1'b1; resolve_tag = 3'd0; tick();
    idle();
    exp_q.push_back(32'({1'b0, 3'd1, 1'b1}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({err, br_tag, br_ready}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL resolve_live: got %h expected %h", {err, br_tag, br_ready}, e);
    end
  endtask

  task automatic test_ring_full;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      br_valid = 1'b1;
      exp_q.push_back(32'({1'b1, 3'(i)}));
      @(negedge clk);
      tests_run++; e = exp_q.pop_front();
      if (32'({br_ready, br_tag}) !== e) begin
        tests_failed++;
        $display("[TB] FAIL tag_alloc_%0d: got %h expected %h", i, {br_ready, br_tag}, e);
      end
      tick();
    end
    br_valid = 1'b1; ren_req = 2'b01;
    exp_q.push_back(32'd0);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({br_ready, ren_ready, fl_checkpoint, fl_i0_read_enable}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_block: got %h expected %h",
               {br_ready, ren_ready, fl_checkpoint, fl_i0_read_enable}, e);
    end
    tick();
    idle(); resolve_valid = 1'b1; resolve_tag = 3'd1; tick();
    idle(); br_valid = 1'b1; resolve_valid = 1'b1; resolve_tag = 3'd0;
    exp_q.push_back(32'd0);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(br_ready) !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_nonhead: got %0d expected %0d", br_ready, e);
    end
    tick();
    resolve_valid = 1'b0;
    exp_q.push_back(32'({1'b1, 3'd0, 1'b1}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({br_ready, br_tag, fl_checkpoint}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL full_release: got %h expected %h", {br_ready, br_tag, fl_checkpoint}, e);
    end
    tick();
    exp_q.push_back(32'({1'b1, 3'd1, 1'b0}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({br_ready, br_tag, err}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL head_chain: got %h expected %h", {br_ready, br_tag, err}, e);
    end
    tick();
    idle();
  endtask

  task automatic test_squash;
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin br_valid = 1'b1; tick(); end
    idle(); mispred_valid = 1'b1; mispred_tag = 3'd1; tick();
    idle(); tick();
    exp_q.push_back(32'({3'd2, 1'b0, 1'b0}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({br_tag, err, fl_restore}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL squash_tail: got %h expected %h", {br_tag, err, fl_restore}, e);
    end
    tick();
    resolve_valid = 1'b1; resolve_tag = 3'd2; tick();
    idle();
    exp_q.push_back(32'd1);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(err) !== e) begin
      tests_failed++;
      $display("[TB] FAIL squashed_resolve_err: got %0d expected %0d", err, e);
    end
  endtask

  task automatic test_back_to_back_mispred;
    logic [31:0] e;
    do_reset();
    br_valid = 1'b1; tick();
    idle(); mispred_valid = 1'b1; tick();
    mispred_valid = 1'b1; tick();
    idle();
    exp_q.push_back(32'({1'b1, 1'b1, 1'b0}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({err, free_ready, fl_restore}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL double_mispred: got %h expected %h", {err, free_ready, fl_restore}, e);
    end
  endtask

  task automatic test_reset_restore;
    logic [31:0] e;
    do_reset();
    ren_req = 2'b11; br_valid = 1'b1; tick();
    idle(); ren_req = 2'b11; tick();
    idle(); mispred_valid = 1'b1; tick();
    idle(); rst_n = 1'b0;
    exp_q.push_back(32'd0);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(fl_restore) !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_restore_gate: got %0d expected %0d", fl_restore, e);
    end
    tick();
    rst_n = 1'b1;
    exp_q.push_back(32'({1'b0, 7'd32, 3'd0, 1'b1}));
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'({fl_restore, free_count, br_tag, free_ready}) !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_restore_abort: got %h expected %h",
               {fl_restore, free_count, br_tag, free_ready}, e);
    end
  endtask

  task automatic test_invalid;
    logic [31:0] e;
    tick();
    fl_invalid_write = 1'b1; tick();
    idle(); tick();
    exp_q.push_back(32'd1);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(err) !== e) begin
      tests_failed++;
      $display("[TB] FAIL invalid_sticky: got %0d expected %0d", err, e);
    end
    do_reset();
    exp_q.push_back(32'd0);
    @(negedge clk);
    tests_run++; e = exp_q.pop_front();
    if (32'(err) !== e) begin
      tests_failed++;
      $display("[TB] FAIL err_clear: got %0d expected %0d", err, e);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_drain();
    test_checkpoint_restore();
    test_ring_full();
    test_squash();
    test_back_to_back_mispred();
    test_reset_restore();
    test_invalid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
